// File: rtl/ahb_mtx_input_stage_if.sv
// Bus bundle between one AHB master port and the matrix output side.
// The slave modport is the input stage's view; the master modport is the environment's view.
interface ahb_mtx_input_stage_if #(
    parameter int unsigned ADDR_WIDTH = 32
);

    localparam int unsigned TRANS_W = 2;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 3;
    localparam int unsigned PROT_W  = 4;

    // master-side address phase
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [TRANS_W-1:0]    HTRANSS;
    logic                  HWRITES;
    logic [SIZE_W-1:0]     HSIZES;
    logic [BURST_W-1:0]    HBURSTS;
    logic [PROT_W-1:0]     HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  HREADYOUTS;
    logic                  HRESPS;

    // output-side arbitration and data-phase handshake
    logic                  addr_grant;
    logic                  out_hready;
    logic                  out_hresp;
    logic                  req;

    // forwarded address phase
    logic                  sel_o;
    logic [TRANS_W-1:0]    trans_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic                  write_o;
    logic [SIZE_W-1:0]     size_o;
    logic [BURST_W-1:0]    burst_o;
    logic [PROT_W-1:0]     prot_o;
    logic                  lock_o;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        input  addr_grant, out_hready, out_hresp,
        output HREADYOUTS, HRESPS, req,
        output sel_o, trans_o, addr_o, write_o, size_o, burst_o, prot_o, lock_o
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        output addr_grant, out_hready, out_hresp,
        input  HREADYOUTS, HRESPS, req,
        input  sel_o, trans_o, addr_o, write_o, size_o, burst_o, prot_o, lock_o
    );

endinterface

// File: rtl/ahb_mtx_input_stage.sv
// Per-master input stage of the AHB bus matrix: forwards or holds the master address phase,
// requests the output arbiter and relays the data-phase handshake back to the master.
module ahb_mtx_input_stage #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    ahb_mtx_input_stage_if.slave    bus
);

    localparam int unsigned TRANS_W = 2;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 3;
    localparam int unsigned PROT_W  = 4;

    typedef struct packed {
        logic                  sel;
        logic [TRANS_W-1:0]    trans;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [SIZE_W-1:0]     size;
        logic [BURST_W-1:0]    burst;
        logic [PROT_W-1:0]     prot;
        logic                  lock;
    } addr_ph_t;

    // EMPTY: no pending address, output does not own our data phase
    // HELD : address captured and waiting for grant, master stalled
    // DATA : output is in the data phase of a transfer from this port
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t   r_state;
    state_t   w_state_nxt;
    addr_ph_t r_hold;
    addr_ph_t w_live;
    addr_ph_t w_fwd;

    logic w_pend;
    logic w_data_ph;
    logic w_live_xfer;
    logic w_accept;
    logic w_capture;
    logic w_hreadyout;
    logic w_hresp;
    logic w_req;

    always_comb begin
        w_live       = '0;
        w_live.sel   = bus.HSELS;
        w_live.trans = bus.HTRANSS;
        w_live.addr  = bus.HADDRS;
        w_live.write = bus.HWRITES;
        w_live.size  = bus.HSIZES;
        w_live.burst = bus.HBURSTS;
        w_live.prot  = bus.HPROTS;
        w_live.lock  = bus.HMASTLOCKS;
    end

    assign w_pend      = (r_state == ST_HELD);
    assign w_data_ph   = (r_state == ST_DATA);
    assign w_live_xfer = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];
    assign w_accept    = bus.addr_grant & bus.out_hready & (w_pend | w_live_xfer);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; a completing data phase and a new capture can share one edge.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_live_xfer) begin
                    if (w_accept) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_HELD;
                        w_capture   = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (w_accept) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.out_hready) begin
                    if (w_accept) begin
                        w_state_nxt = ST_DATA;
                    end else if (w_live_xfer) begin
                        w_state_nxt = ST_HELD;
                        w_capture   = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Holding register stays frozen while pending; only a fresh capture loads it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hold <= '0;
        end else if (w_capture) begin
            r_hold <= w_live;
        end
    end

    always_comb begin
        w_hreadyout = ~w_pend;
        w_hresp     = 1'b0;
        w_fwd       = w_pend ? r_hold : w_live;
        if (w_data_ph) begin
            w_hreadyout = bus.out_hready;
            w_hresp     = bus.out_hresp;
        end
        if (!w_fwd.sel) begin
            w_fwd.trans = '0;
        end
        w_req = w_pend | w_live_xfer | (bus.HSELS & bus.HMASTLOCKS);
    end

    assign bus.HREADYOUTS = w_hreadyout;
    assign bus.HRESPS     = w_hresp;
    assign bus.req        = w_req;
    assign bus.sel_o      = w_fwd.sel;
    assign bus.trans_o    = w_fwd.trans;
    assign bus.addr_o     = w_fwd.addr;
    assign bus.write_o    = w_fwd.write;
    assign bus.size_o     = w_fwd.size;
    assign bus.burst_o    = w_fwd.burst;
    assign bus.prot_o     = w_fwd.prot;
    assign bus.lock_o     = w_fwd.lock;

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Directed bench for the AHB matrix input stage; expected values are hand-computed per cycle.
module tb_ahb_mtx_input_stage;

    localparam int unsigned ADDR_WIDTH = 32;

    logic HCLK;
    logic HRESETn;
    int   n_checks;
    int   n_fail;

    ahb_mtx_input_stage_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    ahb_mtx_input_stage #(.ADDR_WIDTH(ADDR_WIDTH)) u_dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Drive one cycle of master and output-side inputs, then let combinational paths settle.
    task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic write, input logic [2:0] burst, input logic hready,
                         input logic grant, input logic oh, input logic resp);
        bus.HSELS      = sel;
        bus.HTRANSS    = trans;
        bus.HADDRS     = addr;
        bus.HWRITES    = write;
        bus.HBURSTS    = burst;
        bus.HREADYS    = hready;
        bus.addr_grant = grant;
        bus.out_hready = oh;
        bus.out_hresp  = resp;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.HSIZES     = 3'd0;
        bus.HPROTS     = 4'd0;
        bus.HMASTLOCKS = 1'b0;
        HRESETn = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        #10;
        check_eq("rst_hreadyout", 64'(bus.HREADYOUTS), 64'd1);
        check_eq("rst_hresp",     64'(bus.HRESPS),     64'd0);
        check_eq("rst_req",       64'(bus.req),        64'd0);
        check_eq("rst_trans",     64'(bus.trans_o),    64'd0);
        step();
        HRESETn = 1'b1;

        // single NONSEQ write, granted immediately
        step();
        drive(1'b1, 2'b10, 32'h2000_0010, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t1_req",   64'(bus.req),        64'd1);
        check_eq("t1_addr",  64'(bus.addr_o),     64'h2000_0010);
        check_eq("t1_trans", 64'(bus.trans_o),    64'd2);
        check_eq("t1_write", 64'(bus.write_o),    64'd1);
        check_eq("t1_hrdy",  64'(bus.HREADYOUTS), 64'd1);
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t1_dp_hrdy", 64'(bus.HREADYOUTS), 64'd1);
        check_eq("t1_dp_req",  64'(bus.req),        64'd0);

        // NONSEQ read held for three cycles while HADDRS wanders
        step();
        bus.HSIZES = 3'd2;
        bus.HPROTS = 4'b0011;
        drive(1'b1, 2'b10, 32'h0000_0100, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t2_req_a",  64'(bus.req),        64'd1);
        check_eq("t2_hrdy_a", 64'(bus.HREADYOUTS), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            bus.HSIZES = 3'd0;
            bus.HPROTS = 4'd0;
            drive(1'b1, 2'b00, 32'hDEAD_0000 + 32'(i), 1'b0, 3'd0, 1'b0, (i == 2), 1'b1, 1'b0);
            check_eq("t2_held_hrdy",  64'(bus.HREADYOUTS), 64'd0);
            check_eq("t2_held_req",   64'(bus.req),        64'd1);
            check_eq("t2_held_addr",  64'(bus.addr_o),     64'h0000_0100);
            check_eq("t2_held_trans", 64'(bus.trans_o),    64'd2);
        end
        check_eq("t2_held_size", 64'(bus.size_o), 64'd2);
        check_eq("t2_held_prot", 64'(bus.prot_o), 64'd3);
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t2_dp_wait", 64'(bus.HREADYOUTS), 64'd0);
        check_eq("t2_dp_addr", 64'(bus.addr_o),     64'h0);
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t2_dp_done", 64'(bus.HREADYOUTS), 64'd1);

        // INCR4 burst, output stalls two cycles on beat 2
        step();
        drive(1'b1, 2'b10, 32'h0000_0040, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t3_b1_addr",  64'(bus.addr_o),  64'h40);
        check_eq("t3_b1_burst", 64'(bus.burst_o), 64'd3);
        step();
        drive(1'b1, 2'b11, 32'h0000_0044, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_b2_wait1", 64'(bus.HREADYOUTS), 64'd0);
        step();
        drive(1'b1, 2'b11, 32'h0000_0044, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_b2_wait2", 64'(bus.HREADYOUTS), 64'd0);
        check_eq("t3_b2_trans", 64'(bus.trans_o),    64'd3);
        step();
        drive(1'b1, 2'b11, 32'h0000_0044, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t3_b2_go",   64'(bus.HREADYOUTS), 64'd1);
        check_eq("t3_b2_addr", 64'(bus.addr_o),     64'h44);
        step();
        drive(1'b1, 2'b11, 32'h0000_0048, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t3_b3_addr", 64'(bus.addr_o), 64'h48);
        step();
        drive(1'b1, 2'b11, 32'h0000_004C, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t3_b4_hrdy", 64'(bus.HREADYOUTS), 64'd1);
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t3_last_dp", 64'(bus.HREADYOUTS), 64'd1);
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t3_dp_clear", 64'(bus.HREADYOUTS), 64'd1);

        // data phase completes on the same edge a new NONSEQ is captured
        step();
        drive(1'b1, 2'b10, 32'h0000_0300, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 2'b10, 32'h0000_0304, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t4_cap_hrdy", 64'(bus.HREADYOUTS), 64'd1);
        check_eq("t4_cap_req",  64'(bus.req),        64'd1);
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t4_held_hrdy", 64'(bus.HREADYOUTS), 64'd0);
        check_eq("t4_held_addr", 64'(bus.addr_o),     64'h304);
        check_eq("t4_held_req",  64'(bus.req),        64'd1);
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("t4_issue_addr", 64'(bus.addr_o),     64'h304);
        check_eq("t4_issue_hrdy", 64'(bus.HREADYOUTS), 64'd0);
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t4_dp_hrdy", 64'(bus.HREADYOUTS), 64'd1);

        // two-cycle ERROR response, master cancels with IDLE
        step();
        drive(1'b1, 2'b10, 32'h0000_0500, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 2'b10, 32'h0000_0504, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t5_err1_resp", 64'(bus.HRESPS),     64'd1);
        check_eq("t5_err1_hrdy", 64'(bus.HREADYOUTS), 64'd0);
        step();
        drive(1'b1, 2'b00, 32'h0000_0504, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("t5_err2_resp",  64'(bus.HRESPS),     64'd1);
        check_eq("t5_err2_hrdy",  64'(bus.HREADYOUTS), 64'd1);
        check_eq("t5_err2_req",   64'(bus.req),        64'd0);
        check_eq("t5_err2_trans", 64'(bus.trans_o),    64'd0);
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("t5_after_resp", 64'(bus.HRESPS),     64'd0);
        check_eq("t5_after_hrdy", 64'(bus.HREADYOUTS), 64'd1);

        // grant with only IDLE/BUSY present: passthrough, no data phase
        step();
        drive(1'b1, 2'b01, 32'h0000_0600, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t6_busy_trans", 64'(bus.trans_o), 64'd1);
        check_eq("t6_busy_req",   64'(bus.req),     64'd0);
        step();
        drive(1'b0, 2'b10, 32'h0000_0604, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t6_no_dp",    64'(bus.HREADYOUTS), 64'd1);
        check_eq("t6_nosel_tr", 64'(bus.trans_o),    64'd0);
        bus.HMASTLOCKS = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_0604, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t6_lock_req", 64'(bus.req),    64'd1);
        check_eq("t6_lock_fwd", 64'(bus.lock_o), 64'd1);
        bus.HMASTLOCKS = 1'b0;

        // async reset while a transfer is held
        step();
        drive(1'b1, 2'b10, 32'h0000_0700, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 2'b00, 32'h0000_0700, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t7_held_hrdy", 64'(bus.HREADYOUTS), 64'd0);
        check_eq("t7_held_req",  64'(bus.req),        64'd1);
        #2;
        HRESETn = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t7_rst_hrdy",  64'(bus.HREADYOUTS), 64'd1);
        check_eq("t7_rst_req",   64'(bus.req),        64'd0);
        check_eq("t7_rst_trans", 64'(bus.trans_o),    64'd0);
        step();
        HRESETn = 1'b1;
        step();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t7_post_hrdy", 64'(bus.HREADYOUTS), 64'd1);
        check_eq("t7_post_addr", 64'(bus.addr_o),     64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
